// File: rtl/rgmii_mac_rx_if.sv
// Receive byte stream from the RGMII MAC towards the packet parsers.
// master = MAC side (drives the stream), slave = parser side.
interface rgmii_mac_rx_if;
    logic [7:0] mac_rx_data_o;
    logic       mac_rx_valid_o;
    logic       mac_rx_sof_o;
    logic       mac_rx_eof_o;
    logic       mac_rx_fr_good_o;
    logic       mac_rx_fr_err_o;

    modport master (
        output mac_rx_data_o, mac_rx_valid_o, mac_rx_sof_o, mac_rx_eof_o,
               mac_rx_fr_good_o, mac_rx_fr_err_o
    );
    modport slave (
        input  mac_rx_data_o, mac_rx_valid_o, mac_rx_sof_o, mac_rx_eof_o,
               mac_rx_fr_good_o, mac_rx_fr_err_o
    );
endinterface

// File: rtl/rgmii_mac_rx.sv
// RGMII receive MAC: DDR capture, preamble/SFD strip, CRC/RX_ER/length checks.
// MAC_RX_FCS_STRIP_EN: hold back the 4 FCS bytes through a delay line.
module rgmii_mac_rx (
    input  logic           phy_rxc,
    input  logic           rst_n,
    input  logic [3:0]     phy_rxd,
    input  logic           phy_rx_ctl,
    rgmii_mac_rx_if.master rx,
    output logic           mac_rx_clk_o,
    output logic [3:0]     status_o
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] LEN_MIN     = 11'd64;
    localparam logic [10:0] LEN_MAX     = 11'd1522;
    localparam logic [10:0] LEN_SAT     = 11'h7FF;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    assign mac_rx_clk_o = phy_rxc;

    // DDR capture: low nibble + dv on the rising edge, high nibble + ctl on the falling edge
    logic [3:0] lo_r, hi_f;
    logic       dv_r, ctl_f;

    always_ff @(posedge phy_rxc or negedge rst_n) begin
        if (!rst_n) begin
            lo_r <= '0;
            dv_r <= 1'b0;
        end else begin
            lo_r <= phy_rxd;
            dv_r <= phy_rx_ctl;
        end
    end

    always_ff @(negedge phy_rxc or negedge rst_n) begin
        if (!rst_n) begin
            hi_f  <= '0;
            ctl_f <= 1'b0;
        end else begin
            hi_f  <= phy_rxd;
            ctl_f <= phy_rx_ctl;
        end
    end

    logic [7:0] b_data;
    logic       b_dv, b_er;

    always_ff @(posedge phy_rxc or negedge rst_n) begin
        if (!rst_n) begin
            b_data <= '0;
            b_dv   <= 1'b0;
            b_er   <= 1'b0;
        end else begin
            b_data <= {hi_f, lo_r};
            b_dv   <= dv_r;
            b_er   <= dv_r ^ ctl_f;
        end
    end

    state_t      state, state_n;
    logic [31:0] crc, crc_n;
    logic [10:0] len, len_n;
    logic        er_seen, er_seen_n;
    logic        st_crc, st_crc_n, st_er, st_er_n, st_fr, st_fr_n;
    logic [7:0]  data_q, data_n;
    logic        valid_q, valid_n, sof_q, sof_n, eof_q, eof_n;
    logic        good_q, good_n, err_q, err_n;
    logic        start, last_byte, crc_ok, len_ok;
`ifdef MAC_RX_FCS_STRIP_EN
    logic [3:0][7:0] dly, dly_n;
`endif

    // dv_r already holds the next byte's dv, so the current byte is known to be last
    assign last_byte = b_dv & ~dv_r;
    assign crc_ok    = (crc == CRC_RESIDUE);
    assign len_ok    = (len >= LEN_MIN) && (len <= LEN_MAX);

    always_comb begin
        state_n   = state;
        crc_n     = crc;
        len_n     = len;
        er_seen_n = er_seen;
        st_crc_n  = st_crc;
        st_er_n   = st_er;
        st_fr_n   = st_fr;
        data_n    = 8'h00;
        valid_n   = 1'b0;
        sof_n     = 1'b0;
        eof_n     = 1'b0;
        good_n    = 1'b0;
        err_n     = 1'b0;
        start     = 1'b0;
`ifdef MAC_RX_FCS_STRIP_EN
        dly_n     = dly;
`endif
        case (state)
            IDLE: begin
                if (b_dv) begin
                    if (b_data == PRE_BYTE)      state_n = PREAMBLE;
                    else if (b_data == SFD_BYTE) start   = 1'b1;
                    else                         state_n = DROP;
                end
            end
            PREAMBLE: begin
                if (!b_dv) begin
                    state_n = IDLE;
                end else if (b_data == SFD_BYTE) begin
                    start = 1'b1;
                end else if (b_data != PRE_BYTE) begin
                    state_n = DROP;
                    st_fr_n = 1'b1;
                end
            end
            DATA: begin
                if (b_dv) begin
                    crc_n = crc_byte(crc, b_data);
                    if (len != LEN_SAT) len_n = len + 11'd1;
                    if (b_er) begin
                        er_seen_n = 1'b1;
                        st_er_n   = 1'b1;
                    end
`ifdef MAC_RX_FCS_STRIP_EN
                    dly_n = {dly[2:0], b_data};
                    if (len >= 11'd4) begin
                        valid_n = 1'b1;
                        data_n  = dly[3];
                        sof_n   = (len == 11'd4);
                        eof_n   = last_byte;
                    end
`else
                    valid_n = 1'b1;
                    data_n  = b_data;
                    sof_n   = (len == 11'd0);
                    eof_n   = last_byte;
`endif
                end else begin
                    state_n = IDLE;
                    if (crc_ok && !er_seen && len_ok) begin
                        good_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                        if (!crc_ok) st_crc_n = 1'b1;
                        if (!len_ok) st_fr_n  = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!b_dv) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n   = DATA;
            crc_n     = CRC_INIT;
            len_n     = '0;
            er_seen_n = 1'b0;
        end
    end

    always_ff @(posedge phy_rxc or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            crc     <= CRC_INIT;
            len     <= '0;
            er_seen <= 1'b0;
            st_crc  <= 1'b0;
            st_er   <= 1'b0;
            st_fr   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            good_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            crc     <= crc_n;
            len     <= len_n;
            er_seen <= er_seen_n;
            st_crc  <= st_crc_n;
            st_er   <= st_er_n;
            st_fr   <= st_fr_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            sof_q   <= sof_n;
            eof_q   <= eof_n;
            good_q  <= good_n;
            err_q   <= err_n;
        end
    end

`ifdef MAC_RX_FCS_STRIP_EN
    always_ff @(posedge phy_rxc or negedge rst_n) begin
        if (!rst_n) dly <= '0;
        else        dly <= dly_n;
    end
`endif

    assign rx.mac_rx_data_o    = data_q;
    assign rx.mac_rx_valid_o   = valid_q;
    assign rx.mac_rx_sof_o     = sof_q;
    assign rx.mac_rx_eof_o     = eof_q;
    assign rx.mac_rx_fr_good_o = good_q;
    assign rx.mac_rx_fr_err_o  = err_q;
    assign status_o            = {st_fr, st_er, st_crc, state == DATA};
endmodule

// File: tb/tb_rgmii_mac_rx.sv
// Directed + randomized bench for rgmii_mac_rx; frame-level reference model.
module tb_rgmii_mac_rx;
`ifdef MAC_RX_FCS_STRIP_EN
    localparam int STRIP = 1;
`else
    localparam int STRIP = 0;
`endif
    localparam int LAT = STRIP ? 6 : 2;

    logic       phy_rxc = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] phy_rxd = 4'h0;
    logic       phy_rx_ctl = 1'b0;
    logic       mac_rx_clk_o;
    logic [3:0] status_o;

    rgmii_mac_rx_if rx ();

    rgmii_mac_rx dut (
        .phy_rxc     (phy_rxc),
        .rst_n       (rst_n),
        .phy_rxd     (phy_rxd),
        .phy_rx_ctl  (phy_rx_ctl),
        .rx          (rx.master),
        .mac_rx_clk_o(mac_rx_clk_o),
        .status_o    (status_o)
    );

    always #4 phy_rxc = ~phy_rxc;

    int cyc = 0;
    always @(posedge phy_rxc) cyc <= cyc + 1;

    int n_assert = 0, n_fail = 0;

    // monitor: everything the DUT emits, sampled on the falling edge
    logic [7:0] got_q[$];
    bit         got_sof[$], got_eof[$];
    int         n_good = 0, n_err = 0, n_proto = 0, sof_cyc = -1;

    always @(negedge phy_rxc) begin
        if (rx.mac_rx_valid_o) begin
            got_q.push_back(rx.mac_rx_data_o);
            got_sof.push_back(rx.mac_rx_sof_o);
            got_eof.push_back(rx.mac_rx_eof_o);
            if (rx.mac_rx_sof_o) sof_cyc = cyc;
        end else if (rx.mac_rx_sof_o || rx.mac_rx_eof_o) begin
            n_proto++;
        end
        if (rx.mac_rx_fr_good_o && rx.mac_rx_fr_err_o) n_proto++;
        if (rx.mac_rx_fr_good_o) n_good++;
        if (rx.mac_rx_fr_err_o)  n_err++;
    end

    // reference model: expected stream, pulse counts and sticky status
    logic [7:0] body[$];
    logic [7:0] mdl_q[$];
    bit         mdl_sof[$], mdl_eof[$];
    int         mdl_good = 0, mdl_err = 0, cap0 = 0;
    bit         e_crc = 0, e_er = 0, e_fr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c ^= {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_rand(input int n);
        repeat (n) body.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic push_const(input logic [7:0] b, input int n);
        repeat (n) body.push_back(b);
    endtask

    task automatic append_fcs(input logic [31:0] add);
        logic [31:0] c;
        c = crc32(body) + add;
        for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
    endtask

    task automatic model_frame(input bit fcs_ok, input bit had_er);
        int  len  = body.size();
        int  nout = STRIP ? ((len > 4) ? len - 4 : 0) : len;
        bit  lok  = (len >= 64) && (len <= 1522);
        for (int i = 0; i < nout; i++) begin
            mdl_q.push_back(body[i]);
            mdl_sof.push_back(i == 0);
            mdl_eof.push_back(i == nout - 1);
        end
        if (fcs_ok && !had_er && lok) mdl_good++;
        else                          mdl_err++;
        e_crc |= !fcs_ok;
        e_er  |= had_er;
        e_fr  |= !lok;
    endtask

    task automatic clear_mon();
        got_q.delete(); got_sof.delete(); got_eof.delete();
        mdl_q.delete(); mdl_sof.delete(); mdl_eof.delete();
        n_good = 0; n_err = 0; n_proto = 0; sof_cyc = -1;
        mdl_good = 0; mdl_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dv, input logic er);
        @(negedge phy_rxc); #1;
        phy_rxd = b[3:0]; phy_rx_ctl = dv;
        @(posedge phy_rxc); #1;
        phy_rxd = b[7:4]; phy_rx_ctl = dv ^ er;
    endtask

    task automatic send_frame(input int npre, input int er_at, input int gap, input int chk_at);
        repeat (npre) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < body.size(); i++) begin
            send_byte(body[i], 1'b1, i == er_at);
            if (i == 0) cap0 = cyc;
            if (i == chk_at) chk("in-frame status", status_o[0], 1'b1);
        end
        repeat (gap) send_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_all(input string tag);
        int bad = -1;
        repeat (10) @(posedge phy_rxc);
        #1;
        chk({tag, " nbytes"}, got_q.size(), mdl_q.size());
        if (got_q.size() == mdl_q.size())
            foreach (mdl_q[i])
                if (bad < 0 && (got_q[i] !== mdl_q[i] || got_sof[i] !== mdl_sof[i] ||
                                got_eof[i] !== mdl_eof[i])) bad = i;
        chk({tag, " first bad byte"}, bad, -1);
        chk({tag, " fr_good"}, n_good, mdl_good);
        chk({tag, " fr_err"}, n_err, mdl_err);
        chk({tag, " protocol"}, n_proto, 0);
        chk({tag, " status"}, status_o, {e_fr, e_er, e_crc, 1'b0});
        clear_mon();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge phy_rxc);
        #1;
        chk("reset outputs", {rx.mac_rx_data_o, rx.mac_rx_valid_o, rx.mac_rx_sof_o, rx.mac_rx_eof_o,
                              rx.mac_rx_fr_good_o, rx.mac_rx_fr_err_o, status_o}, 16'h0);
        rst_n = 1'b1;
        e_crc = 0; e_er = 0; e_fr = 0;
        clear_mon();
    endtask

    task automatic build_test1();
        body.delete();
        push_const(8'hFF, 6);
        for (int i = 1; i <= 6; i++) body.push_back(8'(i));
        body.push_back(8'h08); body.push_back(8'h00);
        push_const(8'h00, 46);
        append_fcs(32'h0);
    endtask

    initial begin
        // reset state and clock copy
        do_reset();
        chk("clk copy high", mac_rx_clk_o, phy_rxc);
        @(negedge phy_rxc); #1;
        chk("clk copy low", mac_rx_clk_o, phy_rxc);

        // minimal broadcast frame, good
        build_test1();
        send_frame(7, -1, 2, 10);
        model_frame(1, 0);
        chk("sof latency", sof_cyc - cap0, LAT);
        check_all("bcast64");

        // ARP frame, RX_ER on the 0x08 byte, FCS+1
        body.delete();
        push_const(8'hFF, 6); push_rand(6);
        body.push_back(8'h08); body.push_back(8'h06);
        push_rand(28); push_const(8'h00, 18);
        append_fcs(32'h1);
        send_frame(7, 12, 2, -1);
        model_frame(0, 1);
        check_all("arp er+crc");

        // GVSP-sized frames, 1 us gap and then 1-cycle gap
        do_reset();
        body.delete(); push_rand(62); body.push_back(8'h30); append_fcs(32'h0);
        send_frame(7, -1, 125, -1);
        model_frame(1, 0);
        body.delete(); push_rand(70); append_fcs(32'h0);
        send_frame(7, -1, 1, -1);
        model_frame(1, 0);
        body.delete(); push_rand(62); body.push_back(8'h30); append_fcs(32'h0);
        send_frame(7, -1, 2, -1);
        model_frame(1, 0);
        check_all("gvsp b2b");

        // broken preamble: dropped silently, framing sticky set
        send_byte(8'h55, 1, 0); send_byte(8'h55, 1, 0); send_byte(8'h12, 1, 0);
        repeat (8) send_byte(8'($urandom_range(0, 255)), 1, 0);
        send_byte(8'h00, 0, 0);
        e_fr = 1;
        check_all("bad preamble");

        // runt with correct FCS
        do_reset();
        body.delete(); push_rand(16); append_fcs(32'h0);
        send_frame(7, -1, 2, -1);
        model_frame(1, 0);
        check_all("runt20");

        // reset in the middle of DATA
        body.delete(); push_rand(30); append_fcs(32'h0);
        repeat (7) send_byte(8'h55, 1, 0);
        send_byte(8'hD5, 1, 0);
        for (int i = 0; i < 10; i++) send_byte(body[i], 1, 0);
        #1 rst_n = 1'b0;
        #1 chk("async reset outputs", {rx.mac_rx_data_o, rx.mac_rx_valid_o, rx.mac_rx_sof_o,
               rx.mac_rx_eof_o, rx.mac_rx_fr_good_o, rx.mac_rx_fr_err_o, status_o}, 16'h0);
        e_crc = 0; e_er = 0; e_fr = 0;
        clear_mon();
        repeat (3) send_byte(8'h00, 1, 0);
        rst_n = 1'b1;
        repeat (20) send_byte(8'h00, 1, 0);
        send_byte(8'h00, 0, 0);
        check_all("aborted frame");
        build_test1();
        send_frame(7, -1, 2, -1);
        model_frame(1, 0);
        check_all("after abort");

        // length boundaries and counter saturation
        do_reset();
        body.delete(); push_rand(60); append_fcs(32'h0);
        send_frame(7, -1, 2, -1); model_frame(1, 0);
        body.delete(); push_rand(59); append_fcs(32'h0);
        send_frame(7, -1, 2, -1); model_frame(1, 0);
        check_all("len 64/63");
        body.delete(); push_rand(1518); append_fcs(32'h0);
        send_frame(7, -1, 2, -1); model_frame(1, 0);
        check_all("len 1522");
        body.delete(); push_rand(1519); append_fcs(32'h0);
        send_frame(7, -1, 2, -1); model_frame(1, 0);
        check_all("len 1523");
        body.delete(); push_rand(2096); append_fcs(32'h0);
        send_frame(7, -1, 2, -1); model_frame(1, 0);
        check_all("len 2100");

        // randomized frames
        do_reset();
        for (int f = 0; f < 24; f++) begin
            bit fcs_bad = ($urandom_range(0, 3) == 0);
            int er_at;
            body.delete();
            push_rand($urandom_range(0, 100));
            append_fcs(fcs_bad ? 32'($urandom_range(1, 255)) : 32'h0);
            er_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, body.size() - 1) : -1;
            send_frame($urandom_range(0, 7), er_at, $urandom_range(1, 4), -1);
            model_frame(!fcs_bad, er_at >= 0);
            check_all($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
